// File: rtl/seg7_scan_driver_if.sv
// Host-side bus of the seven-segment scan driver: display word/strobe in,
// anode/segment drive and frame marker out.
interface seg7_scan_driver_if;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output data_in, dp_in, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  data_in, dp_in, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner: scan_clk-driven digit sequencer with
// blanking slots, double-buffered display word and leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 3,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_clk,
    seg7_scan_driver_if.slave   bus
);
    typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    localparam logic [3:0] LAST_CNT   = 4'(DIGIT_TICKS - 1);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic        sync1_r, sync2_r, sync3_r;
    logic        tick_s;
    state_t      state_r, state_s;
    logic [2:0]  digit_r, digit_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        wrap_s;
    logic [31:0] pending_data_r, shadow_data_r;
    logic [7:0]  pending_dp_r, shadow_dp_r;
    logic        pending_valid_r;
    logic [7:0]  an_r, an_s;
    logic [6:0]  seg_r, seg_s;
    logic        dp_r, dp_s;
    logic        frame_done_r;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digit idx is a leading zero when it and every higher active nibble are zero.
    function automatic logic lead_zero(input logic [31:0] d, input logic [2:0] idx);
        logic z;
        z = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i >= int'(idx)) && (i < NUM_DIGITS) && (d[4*i +: 4] != 4'h0)) begin
                z = 1'b0;
            end else begin
                z = z;
            end
        end
        return z && (idx != 3'd0);
    endfunction

    assign tick_s = sync2_r & ~sync3_r;

    // scan_clk synchroniser and rising-edge flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= scan_clk;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BLANK;
            digit_r <= 3'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            digit_r <= digit_s;
            cnt_r   <= cnt_s;
        end
    end

    // Sequencer next state: one step per tick, frame wrap after the last digit
    always_comb begin
        state_s = state_r;
        digit_s = digit_r;
        cnt_s   = cnt_r;
        wrap_s  = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_BLANK: begin
                    state_s = ST_SHOW;
                    cnt_s   = 4'd0;
                end
                ST_SHOW: begin
                    if (cnt_r == LAST_CNT) begin
                        state_s = ST_BLANK;
                        cnt_s   = 4'd0;
                        if (digit_r == LAST_DIGIT) begin
                            digit_s = 3'd0;
                            wrap_s  = 1'b1;
                        end else begin
                            digit_s = digit_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
                default: state_s = ST_BLANK;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Pending/shadow double buffer; the shadow only changes at a frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_data_r  <= 32'h0;
            pending_dp_r    <= 8'h00;
            pending_valid_r <= 1'b0;
            shadow_data_r   <= 32'h0;
            shadow_dp_r     <= 8'h00;
        end else begin
            if (wrap_s && pending_valid_r) begin
                shadow_data_r <= pending_data_r;
                shadow_dp_r   <= pending_dp_r;
            end
            if (bus.load) begin
                pending_data_r  <= bus.data_in;
                pending_dp_r    <= bus.dp_in;
                pending_valid_r <= 1'b1;
            end else if (wrap_s) begin
                pending_valid_r <= 1'b0;
            end
        end
    end

    // Display drive for the current state and digit
    always_comb begin
        an_s  = 8'hFF;
        seg_s = 7'h7F;
        dp_s  = 1'b1;
        if (state_r == ST_SHOW) begin
            an_s = ~(8'h01 << digit_r);
            dp_s = ~shadow_dp_r[digit_r];
            if ((LZ_SUPPRESS != 0) && lead_zero(shadow_data_r, digit_r)) begin
                seg_s = 7'h7F;
            end else begin
                seg_s = hex_to_seg(shadow_data_r[{digit_r, 2'b00} +: 4]);
            end
        end else begin
            an_s = 8'hFF;
        end
    end

    // Registered display outputs and frame marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r         <= 8'hFF;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            frame_done_r <= wrap_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: expected digit records are queued as
// frames are scheduled and popped as each digit lights up.
module tb_seg7_scan_driver;
    logic clk;
    logic rst;
    logic scan_clk;
    logic scan_en;
    int   div_cnt;
    int   n_cmp;
    int   n_mis;
    int   an4_bad;
    int   fd4_cnt;

    logic [15:0] exp_q[$];
    logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg7_scan_driver_if bus ();
    seg7_scan_driver_if bus4 ();

    seg7_scan_driver dut (.clk(clk), .rst(rst), .scan_clk(scan_clk), .bus(bus));
    seg7_scan_driver #(.NUM_DIGITS(4)) dut4 (.clk(clk), .rst(rst), .scan_clk(scan_clk), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scan_clk: period of 8 clk, frozen at its level while scan_en is low
    always @(negedge clk) begin
        if (scan_en) begin
            if (div_cnt == 3) begin
                div_cnt  <= 0;
                scan_clk <= ~scan_clk;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus4.an[7:4] !== 4'hF) an4_bad <= an4_bad + 1;
        if (bus4.frame_done === 1'b1) fd4_cnt <= fd4_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rec(input logic [31:0] d, input logic [7:0] p, input int i);
        logic [7:0] a;
        logic [6:0] s;
        a = 8'hFF & ~(8'h01 << i);
        if ((i > 0) && ((d >> (4 * i)) == 32'h0)) s = 7'h7F;
        else s = seg_tab[d[4*i +: 4]];
        return {a, s, ~p[i]};
    endfunction

    task automatic push_frame(input logic [31:0] d, input logic [7:0] p);
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_rec(d, p, i));
    endtask

    // mode 0: wait blank, 1: wait any digit lit, 2: wait an == target
    task automatic wait_an(input int mode, input logic [7:0] target, input string tag);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 600 && !hit; n++) begin
            @(posedge clk); #1;
            case (mode)
                0:       hit = (bus.an == 8'hFF);
                1:       hit = (bus.an != 8'hFF);
                default: hit = (bus.an == target);
            endcase
        end
        chk({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic wait_fd();
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            @(posedge clk); #1;
            hit = bus.frame_done;
        end
        chk("frame_done_reached", 32'(hit), 32'd1);
    endtask

    task automatic check_digits(input int first, input int last);
        logic [15:0] e;
        for (int i = first; i <= last; i++) begin
            wait_an(0, 8'h00, "blank");
            wait_an(1, 8'h00, "lit");
            e = exp_q.pop_front();
            chk($sformatf("an_d%0d", i), 32'(bus.an), 32'(e[15:8]));
            chk($sformatf("seg_d%0d", i), 32'(bus.seg), 32'(e[7:1]));
            chk($sformatf("dp_d%0d", i), 32'(bus.dp), 32'(e[0]));
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p);
        @(posedge clk); #1;
        bus.data_in = d;
        bus.dp_in   = p;
        bus.load    = 1'b1;
        @(posedge clk); #1;
        bus.load    = 1'b0;
    endtask

    initial begin
        int          rises;
        logic        prev;
        int          hold_bad;
        int          hold_fd;
        logic [15:0] hold_exp;

        n_cmp = 0; n_mis = 0; an4_bad = 0; fd4_cnt = 0;
        div_cnt = 0; scan_clk = 1'b0; scan_en = 1'b0; rst = 1'b1;
        bus.data_in = 32'h0; bus.dp_in = 8'h00; bus.load = 1'b0;
        bus4.data_in = 32'h0; bus4.dp_in = 8'h00; bus4.load = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("rst_an", 32'(bus.an), 32'h0000_00FF);
        chk("rst_seg", 32'(bus.seg), 32'h0000_007F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        scan_en = 1'b1;

        // first rise: nothing visible until three edges later
        @(posedge scan_clk);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        chk("latency_an_k2", 32'(bus.an), 32'h0000_00FF);
        @(posedge clk); #1;
        chk("latency_an_k3", 32'(bus.an), 32'h0000_00FE);
        chk("first_seg", 32'(bus.seg), 32'h0000_0040);
        chk("first_dp", 32'(bus.dp), 32'd1);

        rises = 1;
        prev  = scan_clk;
        for (int n = 0; n < 400 && !bus.frame_done; n++) begin
            @(posedge clk); #1;
            if (scan_clk && !prev) rises++;
            prev = scan_clk;
        end
        chk("ticks_per_frame", 32'(rises), 32'd32);
        @(posedge clk); #1;
        chk("frame_done_width", 32'(bus.frame_done), 32'd0);

        // shadow 0; mid-frame load must not change the remainder of this frame
        push_frame(32'h0, 8'h00);
        check_digits(0, 2);
        do_load(32'h8888_8888, 8'h00);
        check_digits(3, 7);
        wait_fd();

        push_frame(32'h8888_8888, 8'h00);
        do_load(32'h0000_12AF, 8'h04);
        check_digits(0, 7);
        wait_fd();

        push_frame(32'h0000_12AF, 8'h04);
        check_digits(0, 7);
        // digit 7 just lit: the third following rise ends the frame
        repeat (3) @(posedge scan_clk);
        @(posedge clk);
        @(posedge clk); #1;
        bus.data_in = 32'h0000_0305;
        bus.dp_in   = 8'h80;
        bus.load    = 1'b1;
        @(posedge clk); #1;
        chk("load_on_wrap_fd", 32'(bus.frame_done), 32'd1);
        bus.load = 1'b0;

        push_frame(32'h0000_12AF, 8'h04);
        check_digits(0, 7);
        wait_fd();

        push_frame(32'h0000_0305, 8'h80);
        check_digits(0, 3);
        scan_en  = 1'b0;
        hold_exp = exp_rec(32'h0000_0305, 8'h80, 3);
        hold_bad = 0;
        hold_fd  = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if ({bus.an, bus.seg, bus.dp} !== hold_exp) hold_bad++;
            if (bus.frame_done !== 1'b0) hold_fd++;
        end
        chk("hold_changed_cycles", 32'(hold_bad), 32'd0);
        chk("hold_frame_done", 32'(hold_fd), 32'd0);
        scan_en = 1'b1;
        check_digits(4, 7);
        wait_fd();

        // pending load then reset during digit 5: load and shadow are lost
        do_load(32'hFFFF_FFFF, 8'hFF);
        wait_an(2, 8'hDF, "digit5");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_an", 32'(bus.an), 32'h0000_00FF);
        chk("async_rst_seg", 32'(bus.seg), 32'h0000_007F);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        push_frame(32'h0, 8'h00);
        check_digits(0, 7);
        wait_fd();
        push_frame(32'h0, 8'h00);
        check_digits(0, 7);
        wait_fd();

        chk("nd4_upper_anodes_bad", 32'(an4_bad), 32'd0);
        chk("nd4_frames_seen", 32'(fd4_cnt != 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
